// File: rtl/fnd_pkg.sv
// fnd_pkg: shared state type, sizes and nibble check for the FND BCD path; FND_BCD_CHECK_EN enables invalid-nibble detection
package fnd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} fnd_state_e;
  localparam int FND_DIGITS = 4;
  localparam int FND_BIN_W = 14;
  localparam int FND_IDX_W = $clog2(FND_DIGITS);
  localparam logic [3:0] FND_BCD_MAX = 4'd9;
`ifdef FND_BCD_CHECK_EN
  localparam logic FND_CHECK_EN = 1'b1;
`else
  localparam logic FND_CHECK_EN = 1'b0;
`endif
  function automatic logic bcd_invalid(input logic [4*FND_DIGITS-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < FND_DIGITS; i++) bad = bad | (w[4*i +: 4] > FND_BCD_MAX);
    return bad;
  endfunction
endpackage

// File: rtl/fnd_mul10_add.sv
// fnd_mul10_add: one decimal step, acc*10 + nibble truncated to BIN_W
module fnd_mul10_add import fnd_pkg::*; #(
  parameter int BIN_W = FND_BIN_W
) (
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_nib,
  output logic [BIN_W-1:0] o_acc
);
  logic [BIN_W+3:0] ext;
  assign ext = {4'b0, i_acc};
  assign o_acc = BIN_W'((ext << 3) + (ext << 1) + (BIN_W+4)'(i_nib));
endmodule

// File: rtl/fnd_bcd_to_bin.sv
// fnd_bcd_to_bin: iterative 4-digit BCD to binary converter, one digit per clock; FND_BCD_CHECK_EN flags nibbles > 9
module fnd_bcd_to_bin import fnd_pkg::*; (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_bcdValid,
  output logic                    o_bcdReady,
  input  logic [4*FND_DIGITS-1:0] i_bcdDigits,
  output logic                    o_binValid,
  input  logic                    i_binReady,
  output logic [FND_BIN_W-1:0]    o_binCounter,
  output logic                    o_bcdError
);
  fnd_state_e              state_q, state_d;
  logic [4*FND_DIGITS-1:0] word_q, word_d;
  logic [FND_BIN_W-1:0]    acc_q, acc_d, cnt_q, cnt_d, step;
  logic [FND_IDX_W-1:0]    idx_q, idx_d;
  logic                    err_q, err_d;
  logic [3:0]              nib;
  assign nib = word_q[4*idx_q +: 4];
  fnd_mul10_add #(.BIN_W(FND_BIN_W)) u_step (.i_acc(acc_q), .i_nib(nib), .o_acc(step));
  // next-state: accept in IDLE, fold one digit per CONV cycle, hold result in DONE
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (i_bcdValid) begin
        word_d  = i_bcdDigits;
        acc_d   = '0;
        idx_d   = FND_IDX_W'(FND_DIGITS - 1);
        err_d   = FND_CHECK_EN && bcd_invalid(i_bcdDigits);
        state_d = CONV;
      end
      CONV: begin
        acc_d = err_q ? '0 : step;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          cnt_d   = err_q ? '0 : step;
          state_d = DONE;
        end
      end
      DONE: state_d = i_binReady ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_bcdReady   = state_q == IDLE;
  assign o_binValid   = state_q == DONE;
  assign o_binCounter = cnt_q;
  assign o_bcdError   = err_q;
endmodule

// File: tb/tb_fnd_bcd_to_bin.sv
// tb_fnd_bcd_to_bin: directed self-checking bench for fnd_bcd_to_bin
module tb_fnd_bcd_to_bin;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bcd_valid = 1'b0;
  logic        bcd_ready;
  logic [15:0] bcd_digits = '0;
  logic        bin_valid;
  logic        bin_ready = 1'b0;
  logic [13:0] bin_counter;
  logic        bcd_error;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fnd_bcd_to_bin dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_bcdValid(bcd_valid), .o_bcdReady(bcd_ready),
    .i_bcdDigits(bcd_digits), .o_binValid(bin_valid), .i_binReady(bin_ready),
    .o_binCounter(bin_counter), .o_bcdError(bcd_error)
  );

  task automatic convert(input logic [15:0] w, output int lat, output logic [13:0] res, output logic err);
    @(negedge clk);
    bcd_valid  = 1'b1;
    bcd_digits = w;
    bin_ready  = 1'b0;
    @(negedge clk);
    bcd_valid = 1'b0;
    lat = 0;
    while (!bin_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = bin_counter;
    err = bcd_error;
  endtask

  task automatic handshake();
    bin_ready = 1'b1;
    @(negedge clk);
    bin_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests += 4;
    if (bcd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bcd_ready); end
    if (bin_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bin_valid); end
    if (bin_counter !== 14'd0) begin fails++; $display("FAIL reset_counter got %0d want 0", bin_counter); end
    if (bcd_error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", bcd_error); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [13:0] res;
    logic err;
    convert(16'h1234, lat, res, err);
    tests += 3;
    if (lat !== 4) begin fails++; $display("FAIL basic_latency got %0d want 4", lat); end
    if (res !== 14'd1234) begin fails++; $display("FAIL basic_result got %0d want 1234", res); end
    if (err !== 1'b0) begin fails++; $display("FAIL basic_error got %b want 0", err); end
    handshake();
    tests += 2;
    if (bcd_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after got %b want 1", bcd_ready); end
    if (bin_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_after got %b want 0", bin_valid); end
  endtask

  task automatic test_boundaries();
    logic [15:0] words [2] = '{16'h0000, 16'h9999};
    logic [13:0] exp [2] = '{14'd0, 14'h270F};
    int lat;
    logic [13:0] res;
    logic err;
    for (int i = 0; i < 2; i++) begin
      convert(words[i], lat, res, err);
      tests += 3;
      if (lat !== 4) begin fails++; $display("FAIL bound_latency[%h] got %0d want 4", words[i], lat); end
      if (res !== exp[i]) begin fails++; $display("FAIL bound_result[%h] got %0d want %0d", words[i], res, exp[i]); end
      if (err !== 1'b0) begin fails++; $display("FAIL bound_error[%h] got %b want 0", words[i], err); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [13:0] res;
    logic err;
    convert(16'h0507, lat, res, err);
    tests += 1;
    if (res !== 14'd507) begin fails++; $display("FAIL bp_result got %0d want 507", res); end
    for (int i = 0; i < 10; i++) begin
      bcd_valid  = 1'($urandom_range(0, 1));
      bcd_digits = 16'($urandom);
      @(negedge clk);
      tests += 3;
      if (bin_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, bin_valid); end
      if (bin_counter !== 14'd507) begin fails++; $display("FAIL bp_counter[%0d] got %0d want 507", i, bin_counter); end
      if (bcd_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got %b want 0", i, bcd_ready); end
    end
    bcd_valid  = 1'b1;
    bcd_digits = 16'h0999;
    handshake();
    bcd_valid = 1'b0;
    tests += 2;
    if (bcd_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after got %b want 1", bcd_ready); end
    if (bin_counter !== 14'd507) begin fails++; $display("FAIL bp_held got %0d want 507", bin_counter); end
  endtask

  task automatic test_invalid();
    int lat;
    logic [13:0] res;
    logic err;
`ifdef FND_BCD_CHECK_EN
    logic [13:0] exp_a = 14'd0, exp_b = 14'd0;
    logic        exp_e = 1'b1;
`else
    logic [13:0] exp_a = 14'd1304, exp_b = 14'd281;
    logic        exp_e = 1'b0;
`endif
    convert(16'h12A4, lat, res, err);
    tests += 3;
    if (lat !== 4) begin fails++; $display("FAIL inv_latency got %0d want 4", lat); end
    if (res !== exp_a) begin fails++; $display("FAIL inv_12A4_result got %0d want %0d", res, exp_a); end
    if (err !== exp_e) begin fails++; $display("FAIL inv_12A4_error got %b want %b", err, exp_e); end
    handshake();
    convert(16'hFFFF, lat, res, err);
    tests += 2;
    if (res !== exp_b) begin fails++; $display("FAIL inv_FFFF_result got %0d want %0d", res, exp_b); end
    if (err !== exp_e) begin fails++; $display("FAIL inv_FFFF_error got %b want %b", err, exp_e); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [13:0] res;
    logic err;
    @(negedge clk);
    bcd_valid  = 1'b1;
    bcd_digits = 16'h4321;
    @(negedge clk);
    bcd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests += 4;
    if (bcd_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", bcd_ready); end
    if (bin_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", bin_valid); end
    if (bin_counter !== 14'd0) begin fails++; $display("FAIL mid_counter got %0d want 0", bin_counter); end
    if (bcd_error !== 1'b0) begin fails++; $display("FAIL mid_error got %b want 0", bcd_error); end
    @(negedge clk);
    rst_n = 1'b1;
    convert(16'h0042, lat, res, err);
    tests += 2;
    if (lat !== 4) begin fails++; $display("FAIL mid_after_latency got %0d want 4", lat); end
    if (res !== 14'd42) begin fails++; $display("FAIL mid_after_result got %0d want 42", res); end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h0001, 16'h2468, 16'h9000};
    logic [13:0] exp [3] = '{14'd1, 14'd2468, 14'd9000};
    int acc_i = 0, res_i = 0, last = 0;
    bin_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bin_valid && res_i < 3) begin
        tests++;
        if (bin_counter !== exp[res_i]) begin fails++; $display("FAIL b2b_result[%0d] got %0d want %0d", res_i, bin_counter, exp[res_i]); end
        res_i++;
      end
      if (bcd_ready) begin
        if (acc_i < 3) begin
          bcd_valid  = 1'b1;
          bcd_digits = words[acc_i];
          if (acc_i > 0) begin
            tests++;
            if (c - last !== 6) begin fails++; $display("FAIL b2b_spacing[%0d] got %0d want 6", acc_i, c - last); end
          end
          last = c;
          acc_i++;
        end else bcd_valid = 1'b0;
      end
    end
    bin_ready = 1'b0;
    bcd_valid = 1'b0;
    tests += 1;
    if (res_i !== 3) begin fails++; $display("FAIL b2b_count got %0d want 3", res_i); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fnd_bcd_to_bin.md
# fnd_bcd_to_bin

Sequential decimal-to-binary converter for the FND display path. It performs the inverse of the per-digit binary-to-decimal coder: it accepts a packed 4-digit BCD word (keypad or digit-entry result) and produces the 14-bit binary counter value the display and counter logic consume. Conversion is iterative, one digit per clock. Valid/ready handshakes sit on both sides.

## Interface
- DIGITS, 4, number of BCD digits per word; digit DIGITS-1 is most significant.
- BIN_W, 14, binary result width; must hold 10^DIGITS − 1.
- i_clk  in  1  single system clock; all state updates on the rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_bcdValid  in  1  input word present.
- o_bcdReady  out  1  converter can accept a word.
- i_bcdDigits  in  4*DIGITS  packed BCD; [3:0] is ones, [15:12] is thousands.
- o_binValid  out  1  result present.
- i_binReady  in  1  downstream accepts the result.
- o_binCounter  out  BIN_W  binary result.
- o_bcdError  out  1  result came from a word with a nibble > 9; qualified by o_binValid.

## Operation
- **Reset** (asynchronous): state=IDLE, o_bcdReady=1, o_binValid=0, o_binCounter=0, o_bcdError=0, accumulator=0, digit index=0.
- **IDLE**
  - o_bcdReady=1.
  - On i_bcdValid&&o_bcdReady: latch i_bcdDigits, clear the accumulator, set index=DIGITS-1, and go to CONV.
  - The error flag is computed from the latched word.
- **CONV**
  - o_bcdReady=0.
  - Each cycle: acc ← (acc*10 + nibble[index]) truncated to BIN_W, then index decrements.
  - acc*10 is formed as (acc<<3)+(acc<<1) in BIN_W+4 bits before truncation.
  - After the index 0 step, go to DONE.
- **DONE**
  - o_binValid=1. o_binCounter and o_bcdError are held stable until the handshake.
  - On i_binReady: go to IDLE and drop o_binValid the next cycle.
  - i_bcdValid is ignored during DONE, including the handshake cycle.
- **Held output**: o_binCounter keeps its last result after leaving DONE. Only reset or a new completion changes it.
- **Words with no invalid nibble**: the result equals the exact decimal value, 0..9999, with no truncation.
- **Upstream handshake**: i_bcdDigits is sampled only in the accept cycle. Changes to it afterward do not affect the conversion in flight.
- **Reset mid-operation**: abandons the conversion immediately with no partial result. The first accept after reset release is valid.

## Timing
- Accept edge T0; CONV steps at T1..T(DIGITS); o_binValid high after edge T(DIGITS).
- Latency is 4 clocks from accept to valid for DIGITS=4.
- Minimum initiation interval is DIGITS+2 clocks: accept, DIGITS steps, one DONE cycle with i_binReady=1.
- There is no combinational path from i_binReady or i_bcdValid to any output. All outputs are registered or decoded from state.

## Configuration
- **FND_BCD_CHECK_EN defined**
  - At accept, any nibble > 9 sets the error flag.
  - Such words skip the arithmetic and still take the same DIGITS cycles, so latency is unchanged.
  - Result is o_binCounter=0 with o_bcdError=1.
- **FND_BCD_CHECK_EN undefined**
  - No check is made; o_bcdError is tied 0.
  - Nibbles 10..15 enter the arithmetic as-is, and the result wraps modulo 2^BIN_W.
  - Example: 16'hFFFF gives 16665 mod 16384 = 281.

## Structure
- **Shared package fnd_pkg** holds:
  - state enum {IDLE, CONV, DONE}
  - FND_DIGITS=4, FND_BIN_W=14, FND_BCD_MAX=4'd9
- **Sub-module fnd_mul10_add**: combinational step, (acc, nibble) → acc*10+nibble truncated to BIN_W.
  - Instantiated once inside the FSM block.
  - Reusable by a future digit-entry block.

## Test plan
- **Basic conversion**: reset, then submit 16'h1234 with i_binReady=1 → o_binValid rises exactly 4 clocks after accept, o_binCounter=1234, o_bcdError=0, and o_bcdReady returns 1 the cycle after the handshake.
- **Boundaries**: 16'h0000 → 0 and 16'h9999 → 9999 (14'h270F), with no truncation.
- **Downstream backpressure**: hold i_binReady=0 for 10 cycles after 16'h0507 completes → o_binValid stays 1 and o_binCounter stays 507. Toggling i_bcdValid/i_bcdDigits meanwhile has no effect.
- **Invalid nibble**: submit 16'h12A4 → with FND_BCD_CHECK_EN, o_binCounter=0 and o_bcdError=1; without it, 1304 and o_bcdError=0. Also 16'hFFFF without the macro → 281.
- **Reset mid-operation**: assert i_reset_n=0 two clocks after accepting 16'h4321 → all outputs go to reset values asynchronously. After release, 16'h0042 converts to 42 in 4 clocks.
- **Back-to-back**: words held valid continuously → accepts are spaced exactly 6 clocks with i_binReady=1, and the results come out in order.
